// File: rtl/mem_byte_arbiter_pkg.sv
// Shared types and width helpers for the byte-port arbiter family.
// Optional feature macro used by the arbiter top: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;
  localparam int unsigned MAX_IDX_W   = $clog2(MAX_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DRAIN = 2'b10
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return idx_width(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_byte_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after
// 'last', wrapping around; 'last' itself is checked last.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan N slots starting one past the previous winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!valid && req[(32'(last) + k) % N]) begin
        valid = 1'b1;
        idx   = IDX_W'((32'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_byte_arbiter.sv
// Byte-wide memory port arbiter: req/gnt ownership with round-robin choice,
// owner-only strobe forwarding, read-return routing and a sticky error flag.
// Optional macro MEM_ARB_TIMEOUT_EN adds a watchdog that forces release
// after TIMEOUT_CYCLES cycles of ownership.
module mem_byte_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ-1:0]          req_rd,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]        req_wr_data,
  output logic [7:0]                  rd_data,
  output logic [NUM_REQ-1:0]          rd_data_valid,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [7:0]                  mem_wr_data,
  input  logic [7:0]                  mem_rd_data,
  input  logic                        mem_rd_data_valid,
  output logic [idx_width(NUM_REQ)-1:0] owner,
  output logic                        err
);

  localparam int unsigned OWN_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_byte_arbiter: unsupported parameter combination");
  end

  state_e             state;
  logic [OWN_W-1:0]   last_owner;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_next;
  logic               pick_valid;
  logic [OWN_W-1:0]   pick_idx;
  logic               in_grant;
  logic [NUM_REQ-1:0] owned_mask;
  logic               stray_strobe;
  logic               dual_strobe;
  logic               ret_ok;
  logic               spurious_ret;
  logic               overflow;
  logic               timeout_hit;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_pick (
    .req   (req),
    .last  (last_owner),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner-side forwarding and protocol-error detection.
  always_comb begin
    in_grant     = (state == GRANT);
    mem_rd       = in_grant & gnt[owner] & req_rd[owner];
    mem_wr       = in_grant & gnt[owner] & req_wr[owner];
    mem_addr     = req_addr[owner*ADDR_W +: ADDR_W];
    mem_wr_data  = req_wr_data[owner*8 +: 8];
    owned_mask   = in_grant ? gnt : '0;
    stray_strobe = |((req_rd | req_wr) & ~owned_mask);
    dual_strobe  = mem_rd & mem_wr;
    ret_ok       = mem_rd_data_valid & (outstanding != '0);
    spurious_ret = mem_rd_data_valid & (outstanding == '0);
    overflow     = mem_rd & ~ret_ok & (outstanding == OUT_MAX);
  end

  // Reads-in-flight count; an issue and a return in one cycle cancel out.
  always_comb begin
    outstanding_next = outstanding;
    if (mem_rd && !ret_ok && !overflow) begin
      outstanding_next = outstanding + 1'b1;
    end else if (!mem_rd && ret_ok) begin
      outstanding_next = outstanding - 1'b1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Ownership age: idle clears it, so every new grant starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Ownership FSM, grant register, outstanding count and sticky error.
  // A forced release leaves last_owner pointing at the timed-out requester,
  // so round robin only re-picks it when nobody else is requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      last_owner  <= OWN_W'(NUM_REQ - 1);
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (stray_strobe || dual_strobe || spurious_ret || overflow) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= GRANT;
            gnt        <= NUM_REQ'(1) << pick_idx;
            owner      <= pick_idx;
            last_owner <= pick_idx;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            gnt   <= '0;
            state <= (outstanding == '0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (timeout_hit) begin
        state       <= IDLE;
        gnt         <= '0;
        outstanding <= '0;
        err         <= 1'b1;
      end
    end
  end

  // Registered read return, routed to the owner only while it holds the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data       <= '0;
      rd_data_valid <= '0;
    end else begin
      rd_data       <= mem_rd_data;
      rd_data_valid <= (ret_ok && state != IDLE) ? (NUM_REQ'(1) << owner) : '0;
    end
  end

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Self-checking bench for mem_byte_arbiter with a cycle-level reference model.
module tb_mem_byte_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int TO      = 16;

  logic                      clk;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req, gnt, req_rd, req_wr, rd_data_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_wr_data;
  logic [7:0]                rd_data, mem_wr_data, mem_rd_data;
  logic                      mem_rd, mem_wr, mem_rd_data_valid, err;
  logic [ADDR_W-1:0]         mem_addr;
  logic [0:0]                owner;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: ms 0=idle 1=granted 2=draining
  int                 ms, m_owner, m_last, m_out, m_tcnt;
  logic [NUM_REQ-1:0] m_gnt, m_rdv;
  logic               m_err;
  logic [7:0]         m_rdd;

  mem_byte_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .ADDR_W          (ADDR_W),
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .gnt               (gnt),
    .req_rd            (req_rd),
    .req_wr            (req_wr),
    .req_addr          (req_addr),
    .req_wr_data       (req_wr_data),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .mem_rd            (mem_rd),
    .mem_wr            (mem_wr),
    .mem_addr          (mem_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_valid (mem_rd_data_valid),
    .owner             (owner),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    ms = 0; m_owner = 0; m_last = NUM_REQ - 1; m_out = 0; m_tcnt = 0;
    m_gnt = '0; m_rdv = '0; m_err = 1'b0; m_rdd = '0;
  endtask

  task automatic clear_inputs();
    req = '0; req_rd = '0; req_wr = '0; req_addr = '0; req_wr_data = '0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    int  nout, old_ms;
    bit  erd, del, found;
    old_ms = ms;
    erd = (ms == 1) && req_rd[m_owner];
    for (int i = 0; i < NUM_REQ; i++)
      if ((req_rd[i] || req_wr[i]) && !(ms == 1 && i == m_owner)) m_err = 1'b1;
    if (ms == 1 && req_rd[m_owner] && req_wr[m_owner]) m_err = 1'b1;
    del = mem_rd_data_valid && (m_out > 0);
    if (mem_rd_data_valid && m_out == 0) m_err = 1'b1;
    nout = m_out + int'(erd) - int'(del);
    if (nout > MAX_OUT) begin nout = MAX_OUT; m_err = 1'b1; end
    m_rdv = (ms != 0 && del) ? (NUM_REQ'(1) << m_owner) : '0;
    m_rdd = mem_rd_data;
    found = 0;
    case (ms)
      0: for (int k = 1; k <= NUM_REQ; k++) begin
           int c;
           c = (m_last + k) % NUM_REQ;
           if (!found && req[c]) begin
             found = 1; ms = 1; m_owner = c; m_last = c; m_gnt = NUM_REQ'(1) << c; m_tcnt = 0;
           end
         end
      1: if (!req[m_owner]) begin m_gnt = '0; ms = (m_out == 0) ? 0 : 2; end
      default: if (m_out == 0) ms = 0;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    if (old_ms != 0) begin
      if (m_tcnt == TO - 1) begin ms = 0; m_gnt = '0; nout = 0; m_err = 1'b1; end
      else m_tcnt++;
    end
`endif
    m_out = nout;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_checks++; if (rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rdv: got %b expected 00", rd_data_valid); end
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", mem_rd, mem_wr); end
    reset_n = 1'b1;
    model_reset();
    req = 2'b11;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL first_grant: got %b expected 01", gnt); end
    req = 2'b00;
    tick();
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL release_grant: got %b expected 00", gnt); end
  endtask

  task automatic test_write_burst();
    logic [7:0] pat [4];
    pat = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL wb_gnt: got %b expected 10", gnt); end
    n_checks++; if (owner !== 1'b1) begin n_fail++; $display("FAIL wb_owner: got %0d expected 1", owner); end
    for (int j = 0; j < 4; j++) begin
      req_wr = 2'b10;
      req_addr = {32'h100 + 32'(j), $urandom};
      req_wr_data = {pat[j], 8'($urandom)};
      #1;
      n_checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL wb_strobe%0d: got wr=%b rd=%b expected 1/0", j, mem_wr, mem_rd); end
      n_checks++; if (mem_addr !== 32'h100 + 32'(j)) begin n_fail++; $display("FAIL wb_addr%0d: got %h expected %h", j, mem_addr, 32'h100 + 32'(j)); end
      n_checks++; if (mem_wr_data !== pat[j]) begin n_fail++; $display("FAIL wb_data%0d: got %h expected %h", j, mem_wr_data, pat[j]); end
      tick();
    end
    req_wr = '0; req = '0;
    #1;
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL wb_idle_wr: got %b expected 0", mem_wr); end
    tick();
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wb_release: got %b expected 00", gnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wb_err: got %b expected 0", err); end
  endtask

  task automatic test_read_drain();
    int pulses = 0, first_g1 = -1;
    logic [7:0] sent;
    req = 2'b01;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b expected 01", gnt); end
    for (int c = 0; c < 12; c++) begin
      req = {(c >= 5 && c < 9) ? 1'b1 : 1'b0, (c < 4) ? 1'b1 : 1'b0};
      req_rd = {1'b0, (c < 4) ? 1'b1 : 1'b0};
      req_addr = {$urandom, 32'h200 + 32'(c)};
      mem_rd_data_valid = (c >= 3 && c <= 6);
      sent = 8'($urandom);
      mem_rd_data = sent;
      #1;
      n_checks++; if (mem_rd !== (c < 4)) begin n_fail++; $display("FAIL rd_fwd%0d: got %b expected %b", c, mem_rd, (c < 4)); end
      tick();
      if (rd_data_valid[0] === 1'b1) begin
        pulses++;
        n_checks++; if (rd_data !== sent) begin n_fail++; $display("FAIL rd_data%0d: got %h expected %h", c, rd_data, sent); end
      end
      n_checks++; if (rd_data_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rd_nonowner%0d: got %b expected 0", c, rd_data_valid[1]); end
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rd_model_gnt%0d: got %b expected %b", c, gnt, m_gnt); end
      if (first_g1 < 0 && gnt[1] === 1'b1) first_g1 = c;
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL rd_pulses: got %0d expected 4", pulses); end
    n_checks++; if (first_g1 != 8) begin n_fail++; $display("FAIL rd_idle_after_drain: next grant after cycle %0d expected 8", first_g1); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", err); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int seq [4] = '{0, 1, 0, 1};
    for (int g = 0; g < 4; g++) begin
      req = 2'b11;
      tick();
      n_checks++; if (gnt !== (2'b01 << seq[g])) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", g, gnt, 2'b01 << seq[g]); end
      req_wr = 2'b01 << seq[g];
      req_addr = {32'h300 + 32'(g), 32'h400 + 32'(g)};
      #1;
      n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rr_wr%0d: got %b expected 1", g, mem_wr); end
      tick();
      req_wr = '0;
      req = 2'b11 & ~(2'b01 << seq[g]);
      tick();
      n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap%0d: got %b expected 00", g, gnt); end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b expected 0", err); end
    clear_inputs();
  endtask

  task automatic test_errors();
    apply_reset();
    req = 2'b01;
    tick();
    req_wr = 2'b10;
    #1;
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL err_nonowner_wr: got %b expected 0", mem_wr); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
    req_wr = '0; req = '0;
    tick(); tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'h77;
    tick();
    mem_rd_data_valid = 1'b0;
    n_checks++; if (rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL err_spurious_dropped: got %b expected 00", rd_data_valid); end
    apply_reset();
    req = 2'b01;
    tick();
    req_rd = 2'b01; req_wr = 2'b01;
    #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b1) begin n_fail++; $display("FAIL err_dual_fwd: got rd=%b wr=%b expected 1/1", mem_rd, mem_wr); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_dual: got %b expected 1", err); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    int pulses = 0;
    apply_reset();
    req = 2'b01;
    tick();
    for (int j = 0; j < 5; j++) begin
      req_rd = 2'b01;
      #1;
      n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL sat_fwd%0d: got %b expected 1", j, mem_rd); end
      tick();
      n_checks++; if (err !== (j == 4)) begin n_fail++; $display("FAIL sat_err%0d: got %b expected %b", j, err, (j == 4)); end
    end
    req_rd = '0; req = '0;
    tick();
    req = 2'b10;
    for (int j = 0; j < 6; j++) begin
      mem_rd_data_valid = (j < 4);
      tick();
      if (rd_data_valid[0] === 1'b1) pulses++;
      n_checks++; if (gnt !== ((j == 5) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL sat_drain%0d: got %b expected %b", j, gnt, (j == 5) ? 2'b10 : 2'b00); end
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 4", pulses); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    req = 2'b01;
    tick();
    req_rd = 2'b01;
    tick(); tick(); tick();
    req_rd = '0; req = '0; mem_rd_data_valid = 1'b1;
    tick();
    mem_rd_data_valid = 1'b0;
    n_checks++; if (rd_data_valid !== 2'b01) begin n_fail++; $display("FAIL rst_pre_rdv: got %b expected 01", rd_data_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_async_gnt: got %b expected 00", gnt); end
    n_checks++; if (rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL rst_async_rdv: got %b expected 00", rd_data_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_async_err: got %b expected 0", err); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    for (int j = 0; j < 2; j++) begin
      mem_rd_data_valid = 1'b1;
      tick();
      n_checks++; if (rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL rst_late_rdv%0d: got %b expected 00", j, rd_data_valid); end
    end
    mem_rd_data_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rst_late_err: got %b expected 1", err); end
    req = 2'b11;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_idle_grant: got %b expected 01", gnt); end
    clear_inputs();
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    bit done = 0;
    apply_reset();
    req = 2'b01;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (gnt === 2'b01) held++;
      else if (held > 0) done = 1;
    end
    n_checks++; if (!done || held != TO) begin n_fail++; $display("FAIL to_release: held %0d cycles expected %0d", held, TO); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err); end
    req = 2'b11;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL to_skip: got %b expected 10", gnt); end
    clear_inputs();
    tick();
  endtask
`else
  task automatic test_no_timeout();
    apply_reset();
    req = 2'b01;
    tick();
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL hold%0d: got %b expected 01", c, gnt); end
    end
    clear_inputs();
    tick();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        req_rd[i] = (m_gnt[i] && m_out < MAX_OUT) ? ($urandom_range(9) < 3) : ($urandom_range(49) == 0);
        req_wr[i] = m_gnt[i] ? ($urandom_range(9) < 3) : ($urandom_range(49) == 0);
      end
      req_addr = {$urandom, $urandom};
      req_wr_data = 16'($urandom);
      mem_rd_data = 8'($urandom);
      mem_rd_data_valid = (m_out > 0) ? ($urandom_range(9) < 4) : ($urandom_range(29) == 0);
      #1;
      n_checks++; if (mem_rd !== ((ms == 1) && req_rd[m_owner])) begin n_fail++; $display("FAIL rnd_mem_rd%0d: got %b expected %b", c, mem_rd, (ms == 1) && req_rd[m_owner]); end
      n_checks++; if (mem_wr !== ((ms == 1) && req_wr[m_owner])) begin n_fail++; $display("FAIL rnd_mem_wr%0d: got %b expected %b", c, mem_wr, (ms == 1) && req_wr[m_owner]); end
      n_checks++; if (mem_addr !== req_addr[m_owner*ADDR_W +: ADDR_W]) begin n_fail++; $display("FAIL rnd_addr%0d: got %h expected %h", c, mem_addr, req_addr[m_owner*ADDR_W +: ADDR_W]); end
      n_checks++; if (mem_wr_data !== req_wr_data[m_owner*8 +: 8]) begin n_fail++; $display("FAIL rnd_wdata%0d: got %h expected %h", c, mem_wr_data, req_wr_data[m_owner*8 +: 8]); end
      tick();
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt%0d: got %b expected %b", c, gnt, m_gnt); end
      n_checks++; if (owner !== 1'(m_owner)) begin n_fail++; $display("FAIL rnd_owner%0d: got %0d expected %0d", c, owner, m_owner); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err%0d: got %b expected %b", c, err, m_err); end
      n_checks++; if (rd_data_valid !== m_rdv) begin n_fail++; $display("FAIL rnd_rdv%0d: got %b expected %b", c, rd_data_valid, m_rdv); end
      n_checks++; if (rd_data !== m_rdd) begin n_fail++; $display("FAIL rnd_rdata%0d: got %h expected %h", c, rd_data, m_rdd); end
    end
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_write_burst();
    test_read_drain();
    test_round_robin();
    test_errors();
    test_saturation();
    test_reset_mid_drain();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
